// File: rtl/pipe_hazard_ctrl.sv
// IF/ID hazard and sequencing controller: load-use, jump/branch flush and a multicycle FP mul/div tracker.
// Optional macro FP_WB_BYPASS_EN releases FP RAW stalls during the writeback cycle.
module pipe_hazard_ctrl #(
  parameter int FP_MUL_LAT = 4,
  parameter int FP_DIV_LAT = 12
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [5:0] Op_code,
  input  logic [4:0] Rs_ID,
  input  logic [4:0] Rt_ID,
  input  logic [4:0] Fs,
  input  logic [4:0] Fd,
  input  logic [5:0] Funct_ID,
  input  logic       MemRead_EX,
  input  logic [4:0] Rt_EX,
  input  logic       Branch_Taken_EX,
  output logic       IF_stall,
  output logic       IF_Flush,
  output logic       PC_Write,
  output logic       ID_Bubble,
  output logic       FPU_Busy,
  output logic [4:0] FP_Dest,
  output logic       FP_WB
);

  typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

  localparam logic [4:0] MUL_LOAD = 5'(FP_MUL_LAT - 1);
  localparam logic [4:0] DIV_LOAD = 5'(FP_DIV_LAT - 1);

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] dest_q, dest_d;

  logic fp_id, fp_long, jmp_id;
  logic lu, raw, st, stall, issue;

  assign fp_id   = (Op_code == 6'h11);
  assign fp_long = fp_id && (Funct_ID == 6'h02 || Funct_ID == 6'h03);
  assign jmp_id  = (Op_code == 6'h02 || Op_code == 6'h03);

  assign lu = MemRead_EX && (Rt_EX != 5'd0) && (Rt_EX == Rs_ID || Rt_EX == Rt_ID);

`ifdef FP_WB_BYPASS_EN
  // The result is forwarded during WB, so the dependent op may leave ID then.
  assign raw = fp_id && (state_q == BUSY) && (Fs == dest_q || Rt_ID == dest_q);
`else
  assign raw = fp_id && (state_q != IDLE) && (Fs == dest_q || Rt_ID == dest_q);
`endif

  assign st    = fp_long && (state_q != IDLE);
  assign stall = lu || raw || st;
  assign issue = fp_long && !stall && !Branch_Taken_EX;

  // Hazard outputs: reset forcing, then branch > stall > jump.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    IF_stall  = 1'b0;
    IF_Flush  = 1'b0;
    PC_Write  = 1'b1;
    ID_Bubble = 1'b0;
    if (!Rst_n) begin
      IF_Flush  = 1'b1;
      PC_Write  = 1'b0;
      ID_Bubble = 1'b1;
    end else if (Branch_Taken_EX) begin
      IF_Flush  = 1'b1;
      ID_Bubble = 1'b1;
    end else if (stall) begin
      IF_stall  = 1'b1;
      PC_Write  = 1'b0;
      ID_Bubble = 1'b1;
    end else if (jmp_id) begin
      IF_Flush  = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    unique case (state_q)
      IDLE: if (issue) begin
        state_d = BUSY;
        cnt_d   = (Funct_ID == 6'h03) ? DIV_LOAD : MUL_LOAD;
        dest_d  = Fd;
      end
      BUSY: begin
        if (cnt_q == 5'd0) state_d = WB;
        else               cnt_d   = cnt_q - 5'd1;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: asynchronous reset aborts any in-flight op; no WB strobe is emitted afterwards.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      dest_q  <= 5'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
    end
  end

  assign FPU_Busy = (state_q != IDLE);
  assign FP_WB    = (state_q == WB);
  assign FP_Dest  = dest_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: timeline model compared every cycle plus directed literal checks.
module tb_pipe_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 12;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b1;
  logic [5:0] Op_code = '0;
  logic [4:0] Rs_ID = '0, Rt_ID = '0, Fs = '0, Fd = '0, Rt_EX = '0;
  logic [5:0] Funct_ID = '0;
  logic       MemRead_EX = 1'b0, Branch_Taken_EX = 1'b0;
  logic       IF_stall, IF_Flush, PC_Write, ID_Bubble, FPU_Busy, FP_WB;
  logic [4:0] FP_Dest;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_hazard_ctrl #(.FP_MUL_LAT(MUL_LAT), .FP_DIV_LAT(DIV_LAT)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Op_code(Op_code), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .Fs(Fs), .Fd(Fd), .Funct_ID(Funct_ID), .MemRead_EX(MemRead_EX), .Rt_EX(Rt_EX),
    .Branch_Taken_EX(Branch_Taken_EX), .IF_stall(IF_stall), .IF_Flush(IF_Flush),
    .PC_Write(PC_Write), .ID_Bubble(ID_Bubble), .FPU_Busy(FPU_Busy),
    .FP_Dest(FP_Dest), .FP_WB(FP_WB)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: an issued op occupies edges [E0, E0+LAT] and writes back at edge E0+LAT.
  int         m_k = 0;
  int         m_wb_edge = 0;
  bit         m_active = 1'b0;
  logic [4:0] m_dest = '0;
  logic m_fp_id, m_long, m_jmp, m_lu, m_raw, m_st, m_stall, m_issue, m_busy, m_wb;
  logic e_stall, e_flush, e_pc, e_bub;

  always_comb begin
    m_busy  = m_active && (m_k <= m_wb_edge);
    m_wb    = m_active && (m_k == m_wb_edge);
    m_fp_id = (Op_code == 6'h11);
    m_long  = m_fp_id && (Funct_ID inside {6'h02, 6'h03});
    m_jmp   = (Op_code inside {6'h02, 6'h03});
    m_lu    = MemRead_EX && (Rt_EX != 0) && (Rt_EX == Rs_ID || Rt_EX == Rt_ID);
    m_raw   = m_fp_id && m_busy && (Fs == m_dest || Rt_ID == m_dest);
`ifdef FP_WB_BYPASS_EN
    if (m_wb) m_raw = 1'b0;
`endif
    m_st    = m_long && m_busy;
    m_stall = m_lu || m_raw || m_st;
    m_issue = Rst_n && m_long && !m_stall && !Branch_Taken_EX;
    e_stall = 1'b0; e_flush = 1'b0; e_pc = 1'b1; e_bub = 1'b0;
    if (!Rst_n)               begin e_flush = 1'b1; e_pc = 1'b0; e_bub = 1'b1; end
    else if (Branch_Taken_EX) begin e_flush = 1'b1; e_bub = 1'b1; end
    else if (m_stall)         begin e_stall = 1'b1; e_pc = 1'b0; e_bub = 1'b1; end
    else if (m_jmp)           e_flush = 1'b1;
  end

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_active <= 1'b0;
      m_dest   <= '0;
    end else begin
      m_k <= m_k + 1;
      if (m_issue) begin
        m_active  <= 1'b1;
        m_wb_edge <= m_k + 1 + ((Funct_ID == 6'h03) ? DIV_LAT : MUL_LAT);
        m_dest    <= Fd;
      end
    end
  end

  always @(negedge Clk) begin
    check("IF_stall",  {31'd0, IF_stall},  {31'd0, e_stall});
    check("IF_Flush",  {31'd0, IF_Flush},  {31'd0, e_flush});
    check("PC_Write",  {31'd0, PC_Write},  {31'd0, e_pc});
    check("ID_Bubble", {31'd0, ID_Bubble}, {31'd0, e_bub});
    check("FPU_Busy",  {31'd0, FPU_Busy},  {31'd0, m_busy});
    check("FP_WB",     {31'd0, FP_WB},     {31'd0, m_wb});
    check("FP_Dest",   {27'd0, FP_Dest},   {27'd0, m_dest});
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Op_code = '0; Funct_ID = '0; Rs_ID = '0; Rt_ID = '0; Fs = '0; Fd = '0;
    MemRead_EX = 1'b0; Rt_EX = '0; Branch_Taken_EX = 1'b0;
  endtask

  task automatic set_fp(input logic [5:0] funct, input logic [4:0] fs, input logic [4:0] fd);
    idle_inputs();
    Op_code = 6'h11; Funct_ID = funct; Fs = fs; Fd = fd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, wb1, wb2, busy_cnt, wb_cnt, dest_seen, exp_rel;
    bit released;

    // Reset behaviour
    #2 Rst_n = 1'b0;
    tick(); tick();
    @(negedge Clk);
    check("rst_flush",  {31'd0, IF_Flush},  32'd1);
    check("rst_pc",     {31'd0, PC_Write},  32'd0);
    check("rst_bubble", {31'd0, ID_Bubble}, 32'd1);
    tick();
    Rst_n = 1'b1;
    @(negedge Clk);
    check("post_rst_flush", {31'd0, IF_Flush}, 32'd0);
    check("post_rst_pc",    {31'd0, PC_Write}, 32'd1);
    check("post_rst_busy",  {31'd0, FPU_Busy}, 32'd0);

    // Load-use, then Rt_EX == 0 never stalls
    tick();
    MemRead_EX = 1'b1; Rt_EX = 5'd5; Rs_ID = 5'd5;
    @(negedge Clk);
    check("lu_stall",  {31'd0, IF_stall},  32'd1);
    check("lu_bubble", {31'd0, ID_Bubble}, 32'd1);
    check("lu_pc",     {31'd0, PC_Write},  32'd0);
    tick();
    MemRead_EX = 1'b0;
    @(negedge Clk);
    check("lu_one_cycle", {31'd0, IF_stall}, 32'd0);
    tick();
    MemRead_EX = 1'b1; Rt_EX = 5'd0; Rs_ID = 5'd0;
    @(negedge Clk);
    check("lu_r0_nostall", {31'd0, IF_stall}, 32'd0);

    // Jump
    tick();
    idle_inputs();
    Op_code = 6'h02;
    @(negedge Clk);
    check("jmp_flush",  {31'd0, IF_Flush},  32'd1);
    check("jmp_pc",     {31'd0, PC_Write},  32'd1);
    check("jmp_bubble", {31'd0, ID_Bubble}, 32'd0);
    tick();
    idle_inputs();

    // FP div, Fd=7, followed by a dependent FP add reading Fs=7
    set_fp(6'h03, 5'd1, 5'd7);
    tick();
    set_fp(6'h00, 5'd7, 5'd8);
    rel = 0; wb1 = 0; busy_cnt = 0; dest_seen = 0; released = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge Clk);
      if (FPU_Busy) busy_cnt++;
      if (FP_WB) wb1 = c;
      if (c == 1) dest_seen = int'(FP_Dest);
      if (!released && !IF_stall) begin rel = c; released = 1'b1; end
      tick();
      if (released) idle_inputs();
    end
`ifdef FP_WB_BYPASS_EN
    exp_rel = 13;
`else
    exp_rel = 14;
`endif
    check("div_busy_cycles", busy_cnt, 32'd13);
    check("div_wb_cycle",    wb1,      32'd13);
    check("div_dest",        dest_seen, 32'd7);
    check("div_raw_release", rel,      exp_rel);

    // Mul, then a second mul held by the structural hazard
    set_fp(6'h02, 5'd0, 5'd3);
    tick();
    set_fp(6'h02, 5'd0, 5'd9);
    rel = 0; wb1 = 0; wb2 = 0; dest_seen = 0; released = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      if (FP_WB) begin
        if (wb1 == 0) wb1 = c;
        else          wb2 = c;
      end
      if (released && c == rel + 1) dest_seen = int'(FP_Dest);
      if (!released && !IF_stall) begin rel = c; released = 1'b1; end
      tick();
      if (released) idle_inputs();
    end
    check("mul1_wb_cycle",   wb1,       32'd5);
    check("mul2_release",    rel,       32'd6);
    check("mul2_wb_cycle",   wb2,       32'd11);
    check("mul2_dest",       dest_seen, 32'd9);

    // Branch beats load-use while an FP op is in flight
    set_fp(6'h02, 5'd0, 5'd4);
    tick();
    idle_inputs();
    Branch_Taken_EX = 1'b1; MemRead_EX = 1'b1; Rt_EX = 5'd5; Rs_ID = 5'd5;
    @(negedge Clk);
    check("br_flush", {31'd0, IF_Flush}, 32'd1);
    check("br_stall", {31'd0, IF_stall}, 32'd0);
    check("br_pc",    {31'd0, PC_Write}, 32'd1);
    tick();
    idle_inputs();
    wb_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      if (FP_WB) wb_cnt++;
      tick();
    end
    check("br_fp_completes", wb_cnt, 32'd1);

    // Branch suppresses an FP issue sitting in ID
    set_fp(6'h03, 5'd0, 5'd6);
    Branch_Taken_EX = 1'b1;
    tick();
    idle_inputs();
    @(negedge Clk);
    check("br_no_issue", {31'd0, FPU_Busy}, 32'd0);

    // Reset asserted mid-BUSY aborts the op
    tick();
    set_fp(6'h03, 5'd0, 5'd5);
    tick();
    idle_inputs();
    tick(); tick();
    Rst_n = 1'b0;
    #1;
    check("rst_abort_busy", {31'd0, FPU_Busy}, 32'd0);
    check("rst_abort_dest", {27'd0, FP_Dest},  32'd0);
    tick();
    Rst_n = 1'b1;
    wb_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (FP_WB) wb_cnt++;
      tick();
    end
    check("rst_abort_no_wb", wb_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
